spi_burst_ctrl: RTL and testbench
=================================

Name: spi_burst_ctrl

Overview:
- Sequencer in front of the `spi` peripheral. It turns one burst request (config byte plus N bytes) into the register-level write strobes the peripheral needs.
- Streams TX bytes in and RX bytes out over valid/ready. It frees the 68k from polling `spi_active` per byte.
- Sits between the SD/flash boot loader (requester) and the `spi` bus port. The CPU-side mux is outside this block.

Parameters:
- SPI_ADDR, 8'h00, value driven on spi_addr for all accesses.
- IDLE_CFG, 8'b0000_0111, config byte written after every burst (all chip selects deasserted).
- ACK_TIMEOUT, 16, max cycles a strobe is held waiting for spi_ack.
- START_TIMEOUT, 64, max cycles from TX strobe ack to spi_active rising.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  burst request; sampled only in IDLE
- cfg  in  8  config byte (chip select, clock divider); latched on start
- len_m1  in  8  burst length minus one (1..256 bytes); latched on start
- abort  in  1  finish the current byte, then close the burst
- tx_data  in  8  next TX byte
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted this cycle
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data valid, held until rx_ready
- rx_ready  in  1  sink accepts rx_data
- busy  out  1  high from start acceptance to done/err
- done  out  1  one-cycle pulse, burst finished OK
- err  out  1  one-cycle pulse, timeout
- spi_data_write  out  16  [7:0] config, [15:8] TX byte
- spi_data_read  in  16  [15:8] last RX byte
- spi_addr  out  8  constant SPI_ADDR
- spi_lds  out  1  config write strobe
- spi_uds  out  1  TX write strobe; starts one byte shift
- spi_rw  out  1  always 0 (write)
- spi_ack  in  1  peripheral access acknowledge
- spi_active  in  1  shift in progress

Behaviour:
- Reset values:
  - All strobes, busy, done, err, tx_ready and rx_valid are 0.
  - spi_data_write is 0, rx_data is 0, spi_rw is 0, spi_addr is SPI_ADDR.
  - State is IDLE.
- Reset mid-burst returns everything to reset values immediately. The peripheral is not cleaned up; the requester re-issues.
- States: IDLE, CFG, GET_TX, SEND, WAIT_ACT, WAIT_DONE, PUT_RX, CLOSE, DONE, ERR.
- IDLE:
  - On start=1, latch cfg and len_m1, clear the byte counter, set busy, go to CFG.
- CFG:
  - Drive spi_data_write[7:0]=cfg_q and spi_lds=1 until the cycle spi_ack=1 (inclusive), then go to GET_TX.
  - No ack within ACK_TIMEOUT cycles goes to ERR.
- GET_TX:
  - tx_ready=1.
  - On tx_valid&tx_ready, latch the byte and go to SEND. Waits indefinitely.
  - abort=1 while waiting goes to CLOSE.
- SEND:
  - Drive spi_data_write[15:8]=byte and spi_uds=1 until spi_ack (inclusive), then go to WAIT_ACT.
  - Same timeout rule as CFG.
- WAIT_ACT:
  - Wait for spi_active=1, then go to WAIT_DONE.
  - More than START_TIMEOUT cycles goes to ERR.
- WAIT_DONE:
  - On spi_active=0, capture rx_data=spi_data_read[15:8] in the same edge, go to PUT_RX.
  - No timeout.
- PUT_RX:
  - rx_valid=1 held until rx_ready.
  - On handshake:
    - count==len_m1 or abort_q goes to CLOSE.
    - Otherwise count+1 and go to GET_TX.
- CLOSE:
  - Write IDLE_CFG via spi_lds with the same ack/timeout rule, then go to DONE.
- DONE:
  - done=1 for one cycle, busy=0, return to IDLE.
- ERR:
  - Drive spi_lds with IDLE_CFG one attempt (timeout ignored).
  - err=1 for one cycle, busy=0, return to IDLE.
- abort:
  - Registered (abort_q sticky until burst ends). Never cuts a byte mid-shift.
  - abort during CFG still issues the CFG write, then closes at GET_TX.
- start while busy is ignored. Simultaneous start and abort in IDLE: abort ignored.
- Counter is 8 bits. len_m1=255 gives 256 bytes; the counter never wraps because the compare precedes the increment.
- Strobes are never asserted together. At most one outstanding peripheral access.

Decomposition:
- Package spi_pkg holds:
  - state encoding (localparams for the 10 states);
  - the IDLE_CFG default;
  - field positions of the config byte (cs[2:0], div[7:3]).
- One sub-module, spi_strobe_timer: holds a strobe until ack, counts to a limit, flags a timeout. It is reused for CFG, SEND and CLOSE, and its counter is reused for WAIT_ACT.

Test Plan:
- Single byte:
  - Stimulus: cfg=8'h12, len_m1=0, tx=8'h01, peripheral model returns 8'hFE.
  - Expected: one lds write of 8'h12, one uds write of 8'h01, rx_data=8'hFE, lds write of IDLE_CFG, done pulse, busy low.
- 4-byte burst:
  - Stimulus: tx 8'hA0..8'hA3, rx_ready held low 5 cycles on byte 2.
  - Expected: exactly 4 uds strobes in order, no uds strobe while rx_valid pending, rx values match the model.
- 256-byte burst:
  - Stimulus: len_m1=8'hFF.
  - Expected: 256 uds strobes, counter ends at 255, single done.
- Abort mid-shift:
  - Stimulus: abort asserted during WAIT_DONE of byte 1 of 4.
  - Expected: byte 1 completes and is delivered, no further uds, IDLE_CFG written, done.
- Start timeout:
  - Stimulus: model never raises spi_active.
  - Expected: err after 64 cycles in WAIT_ACT, IDLE_CFG write attempted, busy low.
- Reset mid-burst:
  - Stimulus: reset_n low during WAIT_DONE.
  - Expected: all outputs at reset values within the same cycle. A following start runs a clean 1-byte burst.

Source files
------------

// File: rtl/spi_burst_ctrl_pkg.sv
// Shared state encoding and config-byte constants for the SPI burst sequencer.
package spi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CFG       = 4'd1,
        ST_GET_TX    = 4'd2,
        ST_SEND      = 4'd3,
        ST_WAIT_ACT  = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_PUT_RX    = 4'd6,
        ST_CLOSE     = 4'd7,
        ST_DONE      = 4'd8,
        ST_ERR       = 4'd9
    } state_e;

    localparam logic [7:0] IDLE_CFG_DEFAULT = 8'b0000_0111;

    // Config byte layout: chip selects in the low bits, clock divider above them.
    localparam int CFG_CS_LSB  = 0;
    localparam int CFG_CS_W    = 3;
    localparam int CFG_DIV_LSB = 3;
    localparam int CFG_DIV_W   = 5;

endpackage

// File: rtl/spi_burst_ctrl_strobe_timer.sv
// Cycle counter that runs while a strobe or wait is in progress and flags
// when the limit is reached without an acknowledge.
module spi_strobe_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_i,
    input  logic       ack_i,
    input  logic [7:0] limit_i,
    output logic       expired_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // An ack restarts the count so back-to-back phases each get a full budget.
    always_comb begin
        count_d = count_q;
        if (!run_i || ack_i) begin
            count_d = '0;
        end else if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = run_i && !ack_i && (count_q == limit_i - 8'd1);

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer: turns one request (config byte plus N data bytes) into
// the lds/uds register writes of the spi peripheral, streaming TX/RX bytes.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter logic [7:0] SPI_ADDR      = 8'h00,
    parameter logic [7:0] IDLE_CFG      = IDLE_CFG_DEFAULT,
    parameter int         ACK_TIMEOUT   = 16,
    parameter int         START_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  cfg,
    input  logic [7:0]  len_m1,
    input  logic        abort,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] spi_data_write,
    input  logic [15:0] spi_data_read,
    output logic [7:0]  spi_addr,
    output logic        spi_lds,
    output logic        spi_uds,
    output logic        spi_rw,
    input  logic        spi_ack,
    input  logic        spi_active
);

    localparam logic [7:0] ACK_LIMIT   = 8'(ACK_TIMEOUT);
    localparam logic [7:0] START_LIMIT = 8'(START_TIMEOUT);

    state_e      state_q;
    logic [7:0]  len_q;
    logic [7:0]  count_q;
    logic        abort_q;
    logic [15:0] wdata_q;
    logic        lds_q;
    logic        uds_q;
    logic        txReady_q;
    logic        rxValid_q;
    logic [7:0]  rxData_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic        timerRun;
    logic [7:0]  timerLimit;
    logic        timerExpired;
    logic        timeout;
    logic        abortNow;
    logic        unusedReadLow;

    assign timerRun   = state_q inside {ST_CFG, ST_SEND, ST_WAIT_ACT, ST_CLOSE};
    assign timerLimit = (state_q == ST_WAIT_ACT) ? START_LIMIT : ACK_LIMIT;
    assign timeout    = timerExpired && !((state_q == ST_WAIT_ACT) && spi_active);
    assign abortNow   = abort_q || abort;
    assign unusedReadLow = ^spi_data_read[7:0];

    spi_strobe_timer u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .run_i     (timerRun),
        .ack_i     (spi_ack),
        .limit_i   (timerLimit),
        .expired_o (timerExpired)
    );

    // Any timeout (strobe ack or shift start) leaves through ERR, which makes
    // a single best-effort write of the idle config to release chip selects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            count_q   <= '0;
            abort_q   <= 1'b0;
            wdata_q   <= '0;
            lds_q     <= 1'b0;
            uds_q     <= 1'b0;
            txReady_q <= 1'b0;
            rxValid_q <= 1'b0;
            rxData_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state_q != ST_IDLE && abort) begin
                abort_q <= 1'b1;
            end
            if (timeout) begin
                uds_q         <= 1'b0;
                lds_q         <= 1'b1;
                wdata_q[7:0]  <= IDLE_CFG;
                err_q         <= 1'b1;
                busy_q        <= 1'b0;
                state_q       <= ST_ERR;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            len_q   <= len_m1;
                            count_q <= '0;
                            abort_q <= 1'b0;
                            busy_q  <= 1'b1;
                            wdata_q <= {8'h00, cfg};
                            lds_q   <= 1'b1;
                            state_q <= ST_CFG;
                        end
                    end
                    ST_CFG: begin
                        if (spi_ack) begin
                            lds_q     <= 1'b0;
                            txReady_q <= !abortNow;
                            state_q   <= ST_GET_TX;
                        end
                    end
                    ST_GET_TX: begin
                        if (txReady_q && tx_valid) begin
                            txReady_q     <= 1'b0;
                            wdata_q[15:8] <= tx_data;
                            uds_q         <= 1'b1;
                            state_q       <= ST_SEND;
                        end else if (abortNow) begin
                            txReady_q    <= 1'b0;
                            wdata_q[7:0] <= IDLE_CFG;
                            lds_q        <= 1'b1;
                            state_q      <= ST_CLOSE;
                        end
                    end
                    ST_SEND: begin
                        if (spi_ack) begin
                            uds_q   <= 1'b0;
                            state_q <= ST_WAIT_ACT;
                        end
                    end
                    ST_WAIT_ACT: begin
                        if (spi_active) begin
                            state_q <= ST_WAIT_DONE;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (!spi_active) begin
                            rxData_q  <= spi_data_read[15:8];
                            rxValid_q <= 1'b1;
                            state_q   <= ST_PUT_RX;
                        end
                    end
                    ST_PUT_RX: begin
                        if (rx_ready) begin
                            rxValid_q <= 1'b0;
                            if (count_q == len_q || abortNow) begin
                                wdata_q[7:0] <= IDLE_CFG;
                                lds_q        <= 1'b1;
                                state_q      <= ST_CLOSE;
                            end else begin
                                count_q   <= count_q + 8'd1;
                                txReady_q <= 1'b1;
                                state_q   <= ST_GET_TX;
                            end
                        end
                    end
                    ST_CLOSE: begin
                        if (spi_ack) begin
                            lds_q   <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    ST_ERR: begin
                        lds_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready       = txReady_q;
    assign rx_data        = rxData_q;
    assign rx_valid       = rxValid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign spi_data_write = wdata_q;
    assign spi_addr       = SPI_ADDR;
    assign spi_lds        = lds_q;
    assign spi_uds        = uds_q;
    assign spi_rw         = 1'b0;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a small behavioural model of the
// spi peripheral (delayed ack, eight-cycle shift, RX byte = inverted TX byte).
module tb_spi_burst_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg = 8'h00;
    logic [7:0]  len_m1 = 8'h00;
    logic        abort = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] spi_data_write;
    logic [15:0] spi_data_read = 16'h0000;
    logic [7:0]  spi_addr;
    logic        spi_lds;
    logic        spi_uds;
    logic        spi_rw;
    logic        spi_ack = 1'b0;
    logic        spi_active = 1'b0;

    int total = 0;
    int bad = 0;

    int ackDelay = 0;
    bit noActive = 1'b0;
    int ackWait = 0;
    int shiftPhase = 0;
    int udsCount = 0;
    int ldsCount = 0;
    int overlapCount = 0;
    int udsWhileRx = 0;
    int doneCount = 0;
    logic [7:0] udsLog [0:1023];
    logic [7:0] ldsLog [0:255];

    spi_burst_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .cfg            (cfg),
        .len_m1         (len_m1),
        .abort          (abort),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .spi_data_write (spi_data_write),
        .spi_data_read  (spi_data_read),
        .spi_addr       (spi_addr),
        .spi_lds        (spi_lds),
        .spi_uds        (spi_uds),
        .spi_rw         (spi_rw),
        .spi_ack        (spi_ack),
        .spi_active     (spi_active)
    );

    always #5 clk = ~clk;

    // Peripheral model: acks a held strobe after ackDelay cycles, logs the
    // written byte, and for a TX write runs an eight-cycle spi_active window.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_ack    <= 1'b0;
            spi_active <= 1'b0;
            ackWait    <= 0;
            shiftPhase <= 0;
        end else begin
            spi_ack <= 1'b0;
            if ((spi_lds || spi_uds) && !spi_ack) begin
                if (ackWait >= ackDelay) begin
                    spi_ack <= 1'b1;
                    ackWait <= 0;
                    if (spi_lds) begin
                        ldsLog[ldsCount % 256] <= spi_data_write[7:0];
                        ldsCount <= ldsCount + 1;
                    end else begin
                        udsLog[udsCount % 1024] <= spi_data_write[15:8];
                        udsCount <= udsCount + 1;
                        spi_data_read <= {~spi_data_write[15:8], 8'h5A};
                        if (!noActive) shiftPhase <= 1;
                    end
                end else begin
                    ackWait <= ackWait + 1;
                end
            end else if (!spi_lds && !spi_uds) begin
                ackWait <= 0;
            end
            if (shiftPhase != 0) begin
                shiftPhase <= (shiftPhase == 11) ? 0 : shiftPhase + 1;
                spi_active <= (shiftPhase >= 2 && shiftPhase < 10);
            end
        end
    end

    // Protocol monitor for properties that must hold on every cycle.
    always @(negedge clk) begin
        if (spi_lds && spi_uds) overlapCount++;
        if (spi_uds && rx_valid) udsWhileRx++;
        if (done) doneCount++;
    end

    task automatic applyStimulus(input logic [7:0] c, input logic [7:0] l);
        @(negedge clk);
        cfg = c;
        len_m1 = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feedTx(input logic [7:0] b, output bit ok);
        int n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = tx_ready;
        if (ok) begin
            tx_data = b;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic drainRx(input int stall, output logic [7:0] b, output bit ok, output bit held);
        int n = 0;
        while (!rx_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = rx_valid;
        b = rx_data;
        held = 1'b1;
        if (ok) begin
            repeat (stall) begin
                @(negedge clk);
                if (!rx_valid || rx_data !== b) held = 1'b0;
            end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic waitEnd(output bit sawDone, output bit sawErr, output int n);
        n = 0;
        while (!(done || err) && n < 500) begin
            @(negedge clk);
            n++;
        end
        sawDone = done;
        sawErr = err;
    endtask

    task automatic waitActive(output bit ok);
        int n = 0;
        while (!spi_active && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = spi_active;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, err, tx_ready, rx_valid} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b want 00000", {busy, done, err, tx_ready, rx_valid});
        end
        total++;
        if ({spi_lds, spi_uds, spi_rw} !== 3'b0) begin
            bad++;
            $display("[TB] FAIL reset_strobes: got %b want 000", {spi_lds, spi_uds, spi_rw});
        end
        total++;
        if ({spi_data_write, rx_data, spi_addr} !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: got %h want 00000000", {spi_data_write, rx_data, spi_addr});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte;
        int l0 = ldsCount;
        int u0 = udsCount;
        int d0 = doneCount;
        bit ok, held, sd, se;
        int n;
        logic [7:0] b;
        ackDelay = 1;
        applyStimulus(8'h12, 8'h00);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_busy: got %b want 1", busy);
        end
        feedTx(8'h01, ok);
        drainRx(0, b, ok, held);
        total++;
        if (b !== 8'hFE || !ok) begin
            bad++;
            $display("[TB] FAIL single_rx: got %h ok=%0d want fe", b, ok);
        end
        waitEnd(sd, se, n);
        total++;
        if ({sd, se, busy} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL single_end: got done/err/busy=%b want 100", {sd, se, busy});
        end
        @(negedge clk);
        total++;
        if (ldsCount - l0 !== 2 || ldsLog[l0 % 256] !== 8'h12 || ldsLog[(l0 + 1) % 256] !== 8'h07) begin
            bad++;
            $display("[TB] FAIL single_lds: got n=%0d %h,%h want n=2 12,07",
                     ldsCount - l0, ldsLog[l0 % 256], ldsLog[(l0 + 1) % 256]);
        end
        total++;
        if (udsCount - u0 !== 1 || udsLog[u0 % 1024] !== 8'h01) begin
            bad++;
            $display("[TB] FAIL single_uds: got n=%0d %h want n=1 01", udsCount - u0, udsLog[u0 % 1024]);
        end
        total++;
        if (doneCount - d0 !== 1 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_done_pulse: got %0d pulses done=%b want 1 pulse done=0", doneCount - d0, done);
        end
    endtask

    task automatic test_four_byte;
        int l0 = ldsCount;
        int u0 = udsCount;
        int w0 = udsWhileRx;
        int o0 = overlapCount;
        bit ok, held, sd, se;
        int n;
        logic [7:0] b, txv;
        ackDelay = 2;
        applyStimulus(8'h21, 8'h03);
        for (int i = 0; i < 4; i++) begin
            txv = 8'hA0 + 8'(i);
            if (i == 1) begin
                cfg = 8'hEE;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            feedTx(txv, ok);
            drainRx((i == 2) ? 5 : 0, b, ok, held);
            total++;
            if (b !== ~txv || !ok || !held) begin
                bad++;
                $display("[TB] FAIL four_rx%0d: got %h ok=%0d held=%0d want %h", i, b, ok, held, ~txv);
            end
        end
        waitEnd(sd, se, n);
        total++;
        if ({sd, se} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL four_end: got done/err=%b want 10", {sd, se});
        end
        @(negedge clk);
        total++;
        if (udsCount - u0 !== 4 || udsLog[u0 % 1024] !== 8'hA0 || udsLog[(u0 + 1) % 1024] !== 8'hA1
            || udsLog[(u0 + 2) % 1024] !== 8'hA2 || udsLog[(u0 + 3) % 1024] !== 8'hA3) begin
            bad++;
            $display("[TB] FAIL four_uds_order: got n=%0d first=%h last=%h want 4 a0..a3",
                     udsCount - u0, udsLog[u0 % 1024], udsLog[(u0 + 3) % 1024]);
        end
        total++;
        if (ldsCount - l0 !== 2 || ldsLog[l0 % 256] !== 8'h21) begin
            bad++;
            $display("[TB] FAIL four_lds: got n=%0d first=%h want n=2 first=21", ldsCount - l0, ldsLog[l0 % 256]);
        end
        total++;
        if (udsWhileRx - w0 !== 0 || overlapCount - o0 !== 0) begin
            bad++;
            $display("[TB] FAIL four_strobe_rules: got uds_during_rx=%0d overlap=%0d want 0 0",
                     udsWhileRx - w0, overlapCount - o0);
        end
    endtask

    task automatic test_long_burst;
        int u0 = udsCount;
        int d0 = doneCount;
        bit ok, held, sd, se;
        int n;
        logic [7:0] b, txv;
        ackDelay = 0;
        applyStimulus(8'h05, 8'hFF);
        for (int i = 0; i < 256; i++) begin
            txv = 8'(i) ^ 8'h3C;
            feedTx(txv, ok);
            drainRx(0, b, ok, held);
            total++;
            if (b !== ~txv || !ok) begin
                bad++;
                $display("[TB] FAIL long_rx%0d: got %h ok=%0d want %h", i, b, ok, ~txv);
            end
        end
        waitEnd(sd, se, n);
        @(negedge clk);
        total++;
        if (sd !== 1'b1 || udsCount - u0 !== 256 || doneCount - d0 !== 1 || udsLog[(u0 + 255) % 1024] !== 8'hC3) begin
            bad++;
            $display("[TB] FAIL long_end: got done=%0d uds=%0d pulses=%0d last=%h want 1 256 1 c3",
                     sd, udsCount - u0, doneCount - d0, udsLog[(u0 + 255) % 1024]);
        end
    endtask

    task automatic test_abort;
        int l0 = ldsCount;
        int u0 = udsCount;
        bit ok, held, sd, se;
        int n;
        logic [7:0] b;
        ackDelay = 0;
        applyStimulus(8'h33, 8'h03);
        feedTx(8'hC0, ok);
        waitActive(ok);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drainRx(0, b, ok, held);
        total++;
        if (b !== 8'h3F || !ok) begin
            bad++;
            $display("[TB] FAIL abort_rx: got %h ok=%0d want 3f", b, ok);
        end
        waitEnd(sd, se, n);
        @(negedge clk);
        total++;
        if (sd !== 1'b1 || udsCount - u0 !== 1 || ldsCount - l0 !== 2 || ldsLog[(l0 + 1) % 256] !== 8'h07) begin
            bad++;
            $display("[TB] FAIL abort_close: got done=%0d uds=%0d lds=%0d last_cfg=%h want 1 1 2 07",
                     sd, udsCount - u0, ldsCount - l0, ldsLog[(l0 + 1) % 256]);
        end
    endtask

    task automatic test_abort_cfg;
        int l0 = ldsCount;
        int u0 = udsCount;
        bit sd, se;
        int n;
        ackDelay = 4;
        applyStimulus(8'h44, 8'h02);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        waitEnd(sd, se, n);
        @(negedge clk);
        total++;
        if (sd !== 1'b1 || udsCount - u0 !== 0 || ldsCount - l0 !== 2 || ldsLog[l0 % 256] !== 8'h44) begin
            bad++;
            $display("[TB] FAIL abort_cfg: got done=%0d uds=%0d lds=%0d first=%h want 1 0 2 44",
                     sd, udsCount - u0, ldsCount - l0, ldsLog[l0 % 256]);
        end
        ackDelay = 0;
    endtask

    task automatic test_start_timeout;
        int l0 = ldsCount;
        bit ok, sd, se;
        int n;
        ackDelay = 0;
        noActive = 1'b1;
        applyStimulus(8'h55, 8'h00);
        feedTx(8'h5A, ok);
        waitEnd(sd, se, n);
        total++;
        if ({sd, se, busy} !== 3'b010 || n < 65 || n > 67) begin
            bad++;
            $display("[TB] FAIL start_timeout: got done/err/busy=%b after %0d cycles want 010 after 65..67",
                     {sd, se, busy}, n);
        end
        total++;
        if (spi_lds !== 1'b1 || spi_uds !== 1'b0 || spi_data_write[7:0] !== 8'h07) begin
            bad++;
            $display("[TB] FAIL start_timeout_cfg: got lds=%b uds=%b cfg=%h want 1 0 07",
                     spi_lds, spi_uds, spi_data_write[7:0]);
        end
        @(negedge clk);
        total++;
        if (spi_lds !== 1'b0 || err !== 1'b0 || ldsCount - l0 !== 2 || ldsLog[(l0 + 1) % 256] !== 8'h07) begin
            bad++;
            $display("[TB] FAIL start_timeout_after: got lds=%b err=%b writes=%0d last=%h want 0 0 2 07",
                     spi_lds, err, ldsCount - l0, ldsLog[(l0 + 1) % 256]);
        end
        noActive = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ack_timeout;
        int l0 = ldsCount;
        bit sd, se;
        int n;
        ackDelay = 100;
        applyStimulus(8'h66, 8'h00);
        waitEnd(sd, se, n);
        total++;
        if ({sd, se, busy} !== 3'b010 || n < 14 || n > 17) begin
            bad++;
            $display("[TB] FAIL ack_timeout: got done/err/busy=%b after %0d cycles want 010 after 14..17",
                     {sd, se, busy}, n);
        end
        total++;
        if (spi_lds !== 1'b1 || spi_data_write[7:0] !== 8'h07 || ldsCount - l0 !== 0) begin
            bad++;
            $display("[TB] FAIL ack_timeout_cfg: got lds=%b cfg=%h acked=%0d want 1 07 0",
                     spi_lds, spi_data_write[7:0], ldsCount - l0);
        end
        ackDelay = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int l0, u0;
        bit ok, held, sd, se;
        int n;
        logic [7:0] b;
        ackDelay = 0;
        applyStimulus(8'h77, 8'h01);
        feedTx(8'h88, ok);
        waitActive(ok);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err, tx_ready, rx_valid, spi_lds, spi_uds} !== 7'b0 || spi_data_write !== 16'h0) begin
            bad++;
            $display("[TB] FAIL reset_mid_burst: got flags=%b wdata=%h want 0000000 0000",
                     {busy, done, err, tx_ready, rx_valid, spi_lds, spi_uds}, spi_data_write);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        l0 = ldsCount;
        u0 = udsCount;
        applyStimulus(8'h12, 8'h00);
        feedTx(8'h9A, ok);
        drainRx(0, b, ok, held);
        total++;
        if (b !== 8'h65 || !ok) begin
            bad++;
            $display("[TB] FAIL post_reset_rx: got %h ok=%0d want 65", b, ok);
        end
        waitEnd(sd, se, n);
        @(negedge clk);
        total++;
        if (sd !== 1'b1 || udsCount - u0 !== 1 || ldsCount - l0 !== 2 || ldsLog[l0 % 256] !== 8'h12) begin
            bad++;
            $display("[TB] FAIL post_reset_burst: got done=%0d uds=%0d lds=%0d first=%h want 1 1 2 12",
                     sd, udsCount - u0, ldsCount - l0, ldsLog[l0 % 256]);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_four_byte();
        test_long_burst();
        test_abort();
        test_abort_cfg();
        test_start_timeout();
        test_ack_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
